// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three memory requesters (CPU, DMA read, DMA write)
// and mem_bus_arbiter: requests, grants and the muxed RAM port.
interface mem_bus_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic        we0;
    logic        we1;
    logic        we2;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic [31:0] wdata2;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;

    modport slave (
        input  req, addr0, addr1, addr2, we0, we1, we2, wdata0, wdata1, wdata2,
        output grant, owner, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, addr0, addr1, addr2, we0, we1, we2, wdata0, wdata1, wdata2,
        input  grant, owner, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin 3-way RAM arbiter with one dead cycle between tenures.
// Optional tenure limit compiled in by defining ARB_BURST_LIMIT_EN.
module mem_bus_arbiter #(
    parameter int unsigned BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  cur_owner;
    logic [1:0]  next_owner;
    logic [1:0]  last_owner;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        winner_valid;
    logic [2:0]  owner_mask;
    logic [15:0] burst_cnt;

    assign owner_mask = 3'b001 << cur_owner;

    // Search starts one past the previous owner and wraps 2 -> 0.
    always_comb begin
        winner       = 2'd0;
        winner_valid = 1'b0;
        cand         = 2'd0;
        for (int unsigned i = 1; i <= 3; i++) begin
            cand = 2'(({30'd0, last_owner} + i) % 32'd3);
            if (!winner_valid && bus.req[cand]) begin
                winner       = cand;
                winner_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_owner  <= '0;
            last_owner <= 2'd2;
            burst_cnt  <= '0;
        end else begin
            state     <= next_state;
            cur_owner <= next_owner;
            if (state == GRANT && next_state == HANDOVER)
                last_owner <= cur_owner;
            if (state != GRANT && next_state == GRANT)
                burst_cnt <= '0;
            else if (state == GRANT && burst_cnt != '1)
                burst_cnt <= burst_cnt + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        next_owner = cur_owner;
        case (state)
            IDLE, HANDOVER: begin
                if (winner_valid) begin
                    next_state = GRANT;
                    next_owner = winner;
                end else begin
                    next_state = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[cur_owner])
                    next_state = HANDOVER;
`ifdef ARB_BURST_LIMIT_EN
                else if (burst_cnt == 16'(BURST_MAX - 1) && (bus.req & ~owner_mask) != '0)
                    next_state = HANDOVER;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

`ifndef ARB_BURST_LIMIT_EN
    // Counter is kept for state visibility; it steers nothing in this build.
    logic unused_burst;
    assign unused_burst = (^burst_cnt) ^ (BURST_MAX == 0);
`endif

    always_comb begin
        bus.grant     = '0;
        bus.owner     = 2'd3;
        bus.busy      = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (state == GRANT) begin
            bus.grant = owner_mask;
            bus.owner = cur_owner;
            bus.busy  = 1'b1;
            case (cur_owner)
                2'd0: begin
                    bus.mem_addr  = bus.addr0;
                    bus.mem_we    = bus.we0;
                    bus.mem_wdata = bus.wdata0;
                end
                2'd1: begin
                    bus.mem_addr  = bus.addr1;
                    bus.mem_we    = bus.we1;
                    bus.mem_wdata = bus.wdata1;
                end
                2'd2: begin
                    bus.mem_addr  = bus.addr2;
                    bus.mem_we    = bus.we2;
                    bus.mem_wdata = bus.wdata2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus random traffic
// checked against a tenure-level reference model.
module tb_mem_bus_arbiter;

    localparam int unsigned BMAX = 4;

    logic clk = 1'b0;
    logic reset;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.BURST_MAX(BMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  grant;
        logic [1:0]  owner;
        logic        busy;
        logic [31:0] mem_addr;
        logic        mem_we;
        logic [31:0] mem_wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: current owner (-1 = bus free), previous owner, cycles served.
    int m_owner = -1;
    int m_last  = 2;
    int m_len   = 0;

    logic [31:0] a [3];
    logic [31:0] d [3];
    logic        w [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_step(input logic [2:0] r, input logic rst_n);
        bit preempt;
        bit others;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = 2;
            m_len   = 0;
            return;
        end
        if (m_owner >= 0) begin
            m_len++;
            others  = (r & ~(3'b001 << m_owner)) != 3'b000;
            preempt = 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            preempt = (m_len == int'(BMAX)) && others;
`endif
            if (!r[m_owner] || preempt) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end else if (r != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                if (r[(m_last + k) % 3]) begin
                    m_owner = (m_last + k) % 3;
                    break;
                end
            end
            m_len = 0;
        end
    endfunction

    task automatic cycle(input logic [2:0] r, input logic rst_n, input bit force_we);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a[i] = $urandom;
            d[i] = $urandom;
            w[i] = force_we ? 1'b1 : 1'($urandom_range(0, 1));
        end
        bus.addr0 = a[0]; bus.addr1 = a[1]; bus.addr2 = a[2];
        bus.wdata0 = d[0]; bus.wdata1 = d[1]; bus.wdata2 = d[2];
        bus.we0 = w[0]; bus.we1 = w[1]; bus.we2 = w[2];
        bus.req = r;
        reset   = rst_n;
        model_step(r, rst_n);
        e.grant     = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        e.owner     = (m_owner >= 0) ? 2'(m_owner) : 2'd3;
        e.busy      = (m_owner >= 0);
        e.mem_addr  = (m_owner >= 0) ? a[m_owner] : 32'd0;
        e.mem_we    = (m_owner >= 0) ? w[m_owner] : 1'b0;
        e.mem_wdata = (m_owner >= 0) ? d[m_owner] : 32'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, plus bus-wide invariants.
    int         wait_t [3] = '{0, 0, 0};
    logic [2:0] prev_grant = 3'b000;

    initial begin
        exp_t e;
        bit   new_tenure;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("grant",     32'(bus.grant),     32'(e.grant));
                chk("owner",     32'(bus.owner),     32'(e.owner));
                chk("busy",      32'(bus.busy),      32'(e.busy));
                chk("mem_addr",  bus.mem_addr,       e.mem_addr);
                chk("mem_we",    32'(bus.mem_we),    32'(e.mem_we));
                chk("mem_wdata", bus.mem_wdata,      e.mem_wdata);
                chk("onehot0",   32'($onehot0(bus.grant)), 32'd1);
                chk("we_without_grant", 32'(bus.mem_we && bus.grant == 3'b000), 32'd0);
                if (!reset) begin
                    wait_t = '{0, 0, 0};
                end else begin
                    new_tenure = (bus.grant != 3'b000) && (bus.grant != prev_grant);
                    for (int i = 0; i < 3; i++) begin
                        if (!bus.req[i] || bus.grant[i]) begin
                            wait_t[i] = 0;
                        end else if (new_tenure) begin
                            wait_t[i]++;
                            chk("fairness_wait", 32'(wait_t[i] <= 2), 32'd1);
                        end
                    end
                end
                prev_grant = bus.grant;
            end
        end
    end

    // Reset must clear the bus without waiting for a clock edge.
    initial begin
        forever begin
            @(negedge reset);
            #1;
            if (!reset) begin
                chk("rst_async_grant",  32'(bus.grant),  32'd0);
                chk("rst_async_mem_we", 32'(bus.mem_we), 32'd0);
                chk("rst_async_owner",  32'(bus.owner),  32'd3);
                chk("rst_async_busy",   32'(bus.busy),   32'd0);
            end
        end
    end

    initial begin
        logic [2:0] r;
        reset = 1'b0;
        bus.req = '0;
        bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0; bus.wdata2 = '0;
        bus.we0 = 1'b0; bus.we1 = 1'b0; bus.we2 = 1'b0;
        repeat (2) cycle(3'b000, 1'b0, 1'b0);

        // Tie on first arbitration goes to CPU; CPU holds 5 cycles, then handover to DMA read.
        cycle(3'b111, 1'b1, 1'b0);
        repeat (4) cycle(3'b011, 1'b1, 1'b0);
        repeat (4) cycle(3'b010, 1'b1, 1'b0);
        repeat (3) cycle(3'b000, 1'b1, 1'b0);

        // Rotation: every owner releases after 3 grant cycles and re-requests.
        cycle(3'b000, 1'b0, 1'b0);
        repeat (40) begin
            r = 3'b111;
            if (m_owner >= 0 && m_len == 2) r[m_owner] = 1'b0;
            cycle(r, 1'b1, 1'b0);
        end
        repeat (3) cycle(3'b000, 1'b1, 1'b0);

        // DMA write holds forever while CPU waits: preempted only with the tenure limit.
        cycle(3'b000, 1'b0, 1'b0);
        repeat (2) cycle(3'b100, 1'b1, 1'b0);
        repeat (100) cycle(3'b101, 1'b1, 1'b0);
        repeat (3) cycle(3'b000, 1'b1, 1'b0);

        // Reset in the middle of a DMA-read write tenure.
        cycle(3'b000, 1'b0, 1'b0);
        repeat (3) cycle(3'b010, 1'b1, 1'b1);
        repeat (2) cycle(3'b010, 1'b0, 1'b1);
        repeat (3) cycle(3'b110, 1'b1, 1'b0);
        repeat (2) cycle(3'b000, 1'b1, 1'b0);

        // Random traffic with sticky requests and rare resets.
        r = 3'b000;
        repeat (10000) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            cycle(r, 1'($urandom_range(0, 499) != 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
